// File: rtl/sample_interp_lin.sv
// Linear interpolating upsampler: ramps from the current output to each new
// audio sample over 2^OSR_LOG2 oversample ticks and strobes the DAC per tick.
module sample_interp_lin #(
   parameter int OSR_LOG2 = 4,
   parameter int TRIG_DIV = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [17:0] sample_in,
   input  logic        sample_in_rdy,
   output logic [17:0] sample_out,
   output logic        sample_out_rdy,
   output logic        dac_trig,
   output logic        seg_done
);

   localparam int N  = 1 << OSR_LOG2;
   localparam int AW = 19 + OSR_LOG2;
   localparam int PW = OSR_LOG2 + 1;
   localparam int DW = $clog2(TRIG_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(TRIG_DIV - 1);
   localparam logic [PW-1:0] PHASE_END = PW'(N);

   logic [DW-1:0]        div_cnt;
   logic signed [AW-1:0] acc;
   logic signed [18:0]   diff;
   logic [PW-1:0]        phase;
   logic                 tick;

   assign tick       = (div_cnt == DIV_LAST);
   assign sample_out = acc[OSR_LOG2+17:OSR_LOG2];
   assign seg_done   = (phase == PHASE_END);

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt        <= '0;
         acc            <= '0;
         diff           <= '0;
         phase          <= PHASE_END;
         sample_out_rdy <= 1'b0;
         dac_trig       <= 1'b0;
      end else begin
         div_cnt        <= tick ? '0 : div_cnt + DW'(1);
         sample_out_rdy <= tick;
         dac_trig       <= sample_out_rdy;
         // A new sample restarts the ramp from whatever is on the output now,
         // so early or late inputs never cause a step discontinuity.
         if (sample_in_rdy) begin
            diff  <= {sample_in[17], sample_in} - {sample_out[17], sample_out};
            acc   <= {sample_out[17], sample_out, {OSR_LOG2{1'b0}}};
            phase <= '0;
         end else if (tick && !seg_done) begin
            acc   <= acc + {{OSR_LOG2{diff[18]}}, diff};
            phase <= phase + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sample_interp_lin.sv
// Bench for sample_interp_lin: closed-form interpolation model feeds a scoreboard
// that a negedge monitor drains on every sample_out_rdy.
module tb_sample_interp_lin;

   localparam int OSR_LOG2 = 2;
   localparam int TRIG_DIV = 4;
   localparam int N        = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [17:0] sample_in = '0;
   logic        sample_in_rdy = 1'b0;
   logic [17:0] sample_out;
   logic        sample_out_rdy;
   logic        dac_trig;
   logic        seg_done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int value;
      bit done;
   } exp_t;

   exp_t sb[$];

   sample_interp_lin #(.OSR_LOG2(OSR_LOG2), .TRIG_DIV(TRIG_DIV)) dut (
      .clk(clk),
      .reset(reset),
      .sample_in(sample_in),
      .sample_in_rdy(sample_in_rdy),
      .sample_out(sample_out),
      .sample_out_rdy(sample_out_rdy),
      .dac_trig(dac_trig),
      .seg_done(seg_done)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Output after k of N steps from start s towards target t, floored.
   function automatic int interp(int s, int t, int k);
      return (s * N + k * (t - s)) >>> OSR_LOG2;
   endfunction

   // Reference model: segment start, target and steps taken.
   int   m_div = 0;
   int   m_s = 0;
   int   m_t = 0;
   int   m_k = N;
   bit   m_tick;
   exp_t m_e;

   always @(posedge clk) begin
      if (reset) begin
         m_div = 0;
         m_s   = 0;
         m_t   = 0;
         m_k   = N;
      end else begin
         m_tick = (m_div == TRIG_DIV - 1);
         m_div  = m_tick ? 0 : m_div + 1;
         if (sample_in_rdy) begin
            m_s = interp(m_s, m_t, m_k);
            m_t = int'($signed(sample_in));
            m_k = 0;
         end else if (m_tick && m_k < N) begin
            m_k++;
         end
         if (m_tick) begin
            m_e.value = interp(m_s, m_t, m_k);
            m_e.done  = (m_k == N);
            sb.push_back(m_e);
         end
      end
   end

   // Monitor: inputs only change at negedge+1, so reset seen here is the
   // value the last active edge sampled.
   logic prev_rdy = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      check("dac_trig_follows_rdy", dac_trig, prev_rdy && !reset);
      if (sample_out_rdy === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: sample_out_rdy with out=%0d but no tick expected", $signed(sample_out));
         end else begin
            mon_e = sb.pop_front();
            check("sb_sample_out", $signed(sample_out), mon_e.value);
            check("sb_seg_done", seg_done, mon_e.done);
         end
      end
      prev_rdy = sample_out_rdy;
   end

   task automatic wait_rdy(output int val, output bit done);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sample_out_rdy !== 1'b1 && n < 64);
      if (sample_out_rdy !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_rdy: no sample_out_rdy within %0d clk", n);
      end
      val  = int'($signed(sample_out));
      done = seg_done;
      #1;
   endtask

   task automatic load(int v);
      sample_in     = 18'(v);
      sample_in_rdy = 1'b1;
      @(negedge clk);
      #1;
      sample_in_rdy = 1'b0;
   endtask

   task automatic steps(string nm, int e0, int e1, int e2, int e3);
      int ev[4];
      int v;
      bit d;
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      for (int i = 0; i < 4; i++) begin
         wait_rdy(v, d);
         check(nm, v, ev[i]);
      end
   endtask

   task automatic latency_after_release(string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sample_out_rdy !== 1'b1 && n < 20);
      check({nm, "_latency"}, n, 4);
      check({nm, "_value"}, $signed(sample_out), 0);
      check({nm, "_seg_done"}, seg_done, 1);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int v;
      bit d;

      repeat (3) @(negedge clk);
      check("reset_sample_out", $signed(sample_out), 0);
      check("reset_seg_done", seg_done, 1);
      check("reset_rdy", sample_out_rdy, 0);
      check("reset_dac_trig", dac_trig, 0);
      #1;
      reset = 1'b0;
      latency_after_release("first_tick");

      load(1000);
      steps("ramp_up", 250, 500, 750, 1000);
      wait_rdy(v, d);
      check("ramp_hold", v, 1000);
      check("ramp_hold_seg_done", d, 1);

      load(-1000);
      steps("ramp_down", 500, 0, -500, -1000);
      load(0);
      steps("to_zero", -750, -500, -250, 0);
      load(3);
      steps("floor_pos", 0, 1, 2, 3);
      load(0);
      steps("floor_back", 2, 1, 0, 0);
      load(-1);
      steps("floor_neg", -1, -1, -1, -1);
      load(0);
      steps("floor_from_neg", -1, -1, -1, 0);

      load(1000);
      steps("early_start", 250, 500, 750, 1000);
      load(0);
      steps("to_zero2", 750, 500, 250, 0);
      load(1000);
      wait_rdy(v, d);
      check("early_tick1", v, 250);
      wait_rdy(v, d);
      check("early_tick2", v, 500);
      load(0);
      steps("early_input", 375, 250, 125, 0);

      // Strobe sample_in_rdy exactly on the tick cycle.
      load(1000);
      wait_rdy(v, d);
      wait_rdy(v, d);
      check("coinc_pre", v, 500);
      repeat (3) @(negedge clk);
      #1;
      sample_in     = 18'(0);
      sample_in_rdy = 1'b1;
      @(negedge clk);
      check("coinc_rdy", sample_out_rdy, 1);
      check("coinc_hold", $signed(sample_out), 500);
      #1;
      sample_in_rdy = 1'b0;
      steps("coinc_resume", 375, 250, 125, 0);

      load(-131072);
      steps("to_min", -32768, -65536, -98304, -131072);
      load(131071);
      steps("extreme", -65537, -1, 65535, 131071);

      load(0);
      wait_rdy(v, d);
      wait_rdy(v, d);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_out", $signed(sample_out), 0);
      check("midreset_seg_done", seg_done, 1);
      #1;
      reset = 1'b0;
      latency_after_release("midreset");

      for (int i = 0; i < 120; i++) begin
         int gap;
         gap = $urandom_range(0, 20);
         if (gap > 0) begin
            repeat (gap) @(negedge clk);
            #1;
         end
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b1;
            @(negedge clk);
            #1;
            reset = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            load(int'($signed(18'($urandom_range(0, 15)))) - 8);
         end else begin
            load(int'($signed(18'($urandom))));
         end
      end

      repeat (40) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_interp_lin.md
# sample_interp_lin

Linear interpolating upsampler between the synth voice mixer and `sigma_delta_2order_dac`. Accepts 18-bit signed samples at the audio rate and emits an interpolated 18-bit stream at 2^OSR_LOG2 times that rate. Generates its own oversample tick from a clock divider. Drives the DAC's `sample_in`/`sample_in_rdy`, plus a trigger one cycle later for the DAC's `sample_rate_trig`.

## Interface
- `OSR_LOG2`, 4: log2 of the oversampling ratio. Legal range 1..8. Number of ticks per input segment N = 2^OSR_LOG2.
- `TRIG_DIV`, 64: clk cycles per oversample tick. Minimum 2.
- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `sample_in`  input  18  signed input sample, audio rate.
- `sample_in_rdy`  input  1  one-cycle strobe; `sample_in` is valid.
- `sample_out`  output  18  signed interpolated sample, registered.
- `sample_out_rdy`  output  1  one-cycle strobe; `sample_out` was updated this cycle.
- `dac_trig`  output  1  one-cycle strobe, `sample_out_rdy` delayed 1 clk.
- `seg_done`  output  1  level; high once N steps of the current segment are applied (holding at target).

## Operation
- Divider: `div_cnt` counts 0..TRIG_DIV-1 and wraps. `tick` = (`div_cnt` == TRIG_DIV-1), internal.
- State registers:
  - `acc`: signed, 19+OSR_LOG2 bits.
  - `diff`: signed, 19 bits.
  - `phase`: OSR_LOG2+1 bits, range 0..N.
- Output value is always `sample_out` = `acc`[OSR_LOG2+17:OSR_LOG2], an arithmetic floor of `acc`/N.
- Load, on `sample_in_rdy`:
  - `diff` <= sign-extended `sample_in` minus the current `sample_out`, 19-bit.
  - `acc` <= sign-extended `sample_out` << OSR_LOG2.
  - `phase` <= 0.
  - Interpolation therefore always starts from the value currently being output. There is no discontinuity on early or late inputs.
- Step, on `tick` with no load, while `phase` < N: `acc` <= `acc` + sign-extended `diff`; `phase` <= `phase`+1.
  - When `phase` == N, `acc` equals `sample_in`·N exactly. Further ticks hold `acc`.
  - `seg_done` = (`phase` == N).
- Every `tick` produces `sample_out_rdy` = 1 in the following cycle, whether stepping or holding.
- Simultaneous `sample_in_rdy` and `tick`:
  - Load wins. No step is applied that cycle.
  - The tick still produces `sample_out_rdy`, carrying the unchanged start value.
- Arithmetic cannot overflow. `acc` stays between the start and target values scaled by N, both within 18-bit range.

## Timing
- Reset, 1 clk synchronous, all zero: `div_cnt`, `acc`, `diff`, `sample_out`, `sample_out_rdy`, `dac_trig`.
- `phase` resets to N, so `seg_done` = 1 and the output holds 0.
- Reset asserted mid-segment aborts the segment. The first post-reset tick outputs 0.
- First `tick` occurs in cycle TRIG_DIV-1 after reset deasserts. Ticks then repeat every TRIG_DIV cycles.
- Latency:
  - Tick in cycle T produces the updated `sample_out` and `sample_out_rdy` in T+1, and `dac_trig` in T+2.
  - `sample_in_rdy` never changes `sample_out` directly. The first new step is visible at the first non-coincident tick after the load.
- `dac_trig` lags by one cycle so that the DAC's input register already holds `sample_out` when `sample_rate_trig` fires.
- `sample_in_rdy` strobes arriving faster than every N ticks are legal. Each one restarts the segment.

## Test plan
All scenarios use OSR_LOG2=2 and TRIG_DIV=4.
- Reset: hold `reset` for 3 clk → all outputs 0, `seg_done`=1; first `sample_out_rdy` 4 clk after release, value 0.
- Ramp up: from 0, input 1000 → successive ticks output 250, 500, 750, 1000, 1000; `seg_done` rises with the 4th tick.
- Ramp down and floor:
  - From 1000, input -1000 → 500, 0, -500, -1000.
  - From 0, input 3 → 0, 1, 2, 3.
  - From 0, input -1 → -1, -1, -1, -1.
- Early input: 0→1000 stopped after two ticks (output 500), then input 0 → 375, 250, 125, 0.
- Coincident `sample_in_rdy` and tick:
  - That tick outputs the unchanged value.
  - Stepping resumes at the next tick.
  - `dac_trig` always follows `sample_out_rdy` by exactly 1 clk.
- Extremes and reset mid-segment:
  - From -131072, input 131071 → final output 131071 with no wrap.
  - Asserting `reset` at tick 2 → outputs 0 and the divider restarts.
